// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder: computes {cout, sum} = a + b + cin one bit per clock,
// LSB first, through a single full-adder cell built from two half adders.
// Operands are captured on an accepted start, so a/b/cin may change freely
// while an addition is in progress.
//
// Handshake: start is honoured only in IDLE. busy is high for WIDTH cycles
// while bits are processed; done pulses for one cycle afterwards. sum/cout
// change only on the final RUN edge (or on reset) and are held until then.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request an addition (sampled in IDLE only)
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in
//   sum    out  WIDTH  result, valid when done=1
//   cout   out  1      carry-out, valid when done=1
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse in DONE
// ----------------------------------------------------------------------------

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit processed per edge, busy=1
// DONE  | result just loaded, done=1 for one cycle
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic load, shift, finish;
    logic last_bit;

    // Full-adder cell: HA1 adds the operand bits, HA2 folds in the carry.
    logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;

    half_adder u_ha1 (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (ha1_s),
        .c (ha1_c)
    );

    half_adder u_ha2 (
        .x (ha1_s),
        .y (carry_q),
        .s (fa_s),
        .c (ha2_c)
    );

    assign fa_c = ha1_c | ha2_c;

    // New sum bit enters at the MSB; after WIDTH shifts the LSB has
    // reached bit 0. A one-bit result register has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = fa_s;
        end else begin : g_res_wn
            assign res_next = {fa_s, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            if (load) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= cin;
                cnt_q   <= '0;
                res_sr  <= '0;
            end else if (shift) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                carry_q <= fa_c;
                cnt_q   <= cnt_q + CNT_W'(1);
                res_sr  <= res_next;
            end
            if (finish) begin
                sum_q  <= res_next;
                cout_q <= fa_c;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one addition with a single-cycle start, then follow it to done.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                           input logic [7:0] es, input logic ec, input string tag);
        int  nbusy;
        int  overlap;
        bit  seen;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        nbusy = 0; overlap = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && done) overlap++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int pulses;
        int last_at;
        int gap_bad;
        logic [7:0] cap_sum;
        logic       cap_cout;

        total = 0;
        bad   = 0;

        // 1: reset, with start high during reset
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_no_run", 32'(busy), 32'd0);

        // 2, 3: basic vectors
        run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01");
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c");
        run_add(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "5a_33");

        // 4: operand change and start pulse during RUN are ignored
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; cap_sum = 8'hEE; cap_cout = 1'bx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                cap_sum = sum;
                cap_cout = cout;
            end
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_sum", 32'(cap_sum), 32'h10);
        check("ign_cout", 32'(cap_cout), 32'd0);
        check("ign_idle", 32'(busy), 32'd0);

        // 5: start held high -> done every WIDTH+2 cycles
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        pulses = 0; last_at = 0; gap_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (pulses == 0) begin
                    if (i != 9) gap_bad++;
                end else if (i - last_at != 10) begin
                    gap_bad++;
                end
                pulses++;
                last_at = i;
                check("hold_sum", 32'(sum), 32'h00);
                check("hold_cout", 32'(cout), 32'd1);
            end
        end
        start = 1'b0;
        check("hold_pulses", 32'(pulses), 32'd4);
        check("hold_period", 32'(gap_bad), 32'd0);
        repeat (2) @(negedge clk);
        check("hold_stop", 32'(busy), 32'd0);

        // 6: reset on the 4th RUN cycle aborts and clears the result
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_run4_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'h00);
        check("abort_cout", 32'(cout), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in, one bit per clock.
- Uses a single 1-bit full-adder cell built from two half_adder instances plus an OR for the carry.
- Sequences operand shift registers, the carry flip-flop and the bit counter.
- Gives the design a small-area adder with a start/busy/done handshake, replacing a WIDTH-wide ripple adder where throughput is not critical.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
sum  output  WIDTH  result; valid when done=1, held until next accepted start
cout  output  1  carry-out; valid when done=1, held until next accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE state

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. When rst=1 at a rising edge:
  - state goes to IDLE;
  - sum, cout, busy, done, bit counter, carry FF and shift registers all go to 0.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture a, b into shift regs, cin into carry FF, clear the bit counter and the result shift reg, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1): each edge does the following.
  - Bit cell computes s = a_sr[0] ^ b_sr[0] ^ carry and c = majority(a_sr[0], b_sr[0], carry), via two half adders: HA1(a0,b0) gives s1/c1; HA2(s1,carry) gives s/c2; c = c1 | c2.
  - s is shifted into the MSB of the result shift reg (right shift). a_sr and b_sr shift right. carry <= c. Counter increments.
  - When the counter reaches WIDTH-1 at an edge (the last bit processed), go to DONE on that edge.
  - On that same edge, sum and cout registers load the final result and final carry.
- Latency: start accepted at edge k → RUN during cycles k+1..k+WIDTH → DONE (done=1) in the cycle after edge k+WIDTH → IDLE after the next edge. Start-to-done is WIDTH+1 edges.
- DONE (done=1, busy=0): unconditionally return to IDLE on the next edge.
- start handling outside IDLE:
  - start in RUN or DONE is ignored, not queued.
  - A start held high continuously re-triggers on the first IDLE cycle, giving a back-to-back period of WIDTH+2 cycles.
- Operand stability: a, b, cin may change freely after capture with no effect on the result in progress.
- Output stability: sum and cout change only on the final RUN edge or on reset. They are stable through DONE and IDLE.
- busy and done are never high together. Both are registered and decoded from state; no combinational input-to-output path.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); never truncated.
- Counter width is clog2(WIDTH) bits, minimum 1. For WIDTH=1, RUN lasts exactly one cycle.
- Reset mid-RUN: the operation is aborted and sum/cout are cleared to 0. No done pulse is produced for the aborted operation.

Test Plan:
1. Reset, WIDTH=8: assert rst 2 cycles → sum=0x00, cout=0, busy=0, done=0. start=1 while rst=1 → no RUN entry.
2. a=0x00, b=0x00, cin=0, start 1 cycle → busy high exactly 8 cycles, done pulse 1 cycle on the 9th cycle after accept, sum=0x00, cout=0.
3. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Then a=0x5A, b=0x33, cin=0 → sum=0x8D, cout=0.
4. Accept a=0x0F, b=0x01; change a/b to 0xAA/0x55 and pulse start during RUN → ignored. Result sum=0x10, cout=0; single done pulse.
5. Hold start=1 continuously with a=0x80, b=0x80, cin=0 → repeated done pulses every 10 cycles, each with sum=0x00, cout=1.
6. Assert rst on the 4th RUN cycle of a=0xFF+b=0xFF → IDLE next edge, sum=0, cout=0, no done pulse. A following start with a=0x01, b=0x02 gives sum=0x03, cout=0.
